// File: rtl/program_counter_pkg.sv
// rtl/program_counter_pkg.sv - shared jump encodings and program counter defaults
package program_counter_pkg;

    localparam int          PC_WIDTH        = 16;
    localparam logic [15:0] PC_RESET_VECTOR = 16'h0000;

    // Hack jump field {j1,j2,j3} = {lt, eq, gt}
    typedef enum logic [2:0] {
        JNULL = 3'b000,
        JGT   = 3'b001,
        JEQ   = 3'b010,
        JGE   = 3'b011,
        JLT   = 3'b100,
        JNE   = 3'b101,
        JLE   = 3'b110,
        JMP   = 3'b111
    } jmp_e;

endpackage

// File: rtl/program_counter_if.sv
// rtl/program_counter_if.sv - control, flag and address bundle between CPU core and program counter
interface program_counter_if
    import program_counter_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH
);
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] a_in;
    logic             is_c;
    logic [2:0]       jmp;
    logic             zr;
    logic             ng;
    logic [WIDTH-1:0] pc;
    logic             take;
    logic             jumped;
    logic             wrapped;

    modport master (
        output en, clr, a_in, is_c, jmp, zr, ng,
        input  pc, take, jumped, wrapped
    );

    modport slave (
        input  en, clr, a_in, is_c, jmp, zr, ng,
        output pc, take, jumped, wrapped
    );
endinterface

// File: rtl/program_counter_jump_cond.sv
// rtl/program_counter_jump_cond.sv - combinational Hack jump condition against ALU flags
module jump_cond (
    input  logic [2:0] jmp,
    input  logic       zr,
    input  logic       ng,
    input  logic       is_c,
    output logic       take
);
    logic lt;
    logic eq;
    logic gt;

    assign lt = ng;
    assign eq = zr;
    assign gt = ~zr & ~ng;

    // A-instructions carry no jump field, so they never jump
    assign take = is_c & ((jmp[2] & lt) | (jmp[1] & eq) | (jmp[0] & gt));
endmodule

// File: rtl/program_counter.sv
// rtl/program_counter.sv - instruction-address register with conditional jump load
module program_counter
    import program_counter_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
    input  logic               clk,
    input  logic               rst_n,
    program_counter_if.slave   bus
);
    logic [WIDTH-1:0] pc_q;
    logic             jumped_q;
    logic             wrapped_q;
    logic             take;

    jump_cond u_jump_cond (
        .jmp  (bus.jmp),
        .zr   (bus.zr),
        .ng   (bus.ng),
        .is_c (bus.is_c),
        .take (take)
    );

    // clr outranks en; a taken jump is a plain load and never marks a wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_VECTOR;
            jumped_q  <= 1'b0;
            wrapped_q <= 1'b0;
        end else if (bus.clr) begin
            pc_q      <= RESET_VECTOR;
            jumped_q  <= 1'b0;
            wrapped_q <= 1'b0;
        end else if (bus.en) begin
            if (take) begin
                pc_q     <= bus.a_in;
                jumped_q <= 1'b1;
            end else begin
                pc_q     <= pc_q + WIDTH'(1);
                jumped_q <= 1'b0;
                if (&pc_q) begin
                    wrapped_q <= 1'b1;
                end
            end
        end
    end

    assign bus.pc      = pc_q;
    assign bus.take    = take;
    assign bus.jumped  = jumped_q;
    assign bus.wrapped = wrapped_q;
endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - scoreboard bench for program_counter
module tb_program_counter;
    import program_counter_pkg::*;

    typedef struct {
        logic [15:0] pc;
        logic        jumped;
        logic        wrapped;
    } exp_t;

    localparam logic [15:0] RV = 16'h0000;

    logic clk;
    logic rst_n;

    program_counter_if #(.WIDTH(16)) bus ();

    program_counter #(.WIDTH(16), .RESET_VECTOR(RV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    exp_t        e;
    int          n_cmp;
    int          n_fail;
    logic [15:0] m_pc;
    logic        m_jumped;
    logic        m_wrapped;

    function automatic logic exp_take(logic c, logic [2:0] j, logic z, logic n);
        if (!c) return 1'b0;
        case (j)
            JNULL:   return 1'b0;
            JGT:     return !z && !n;
            JEQ:     return z;
            JGE:     return !n;
            JLT:     return n;
            JNE:     return !z;
            JLE:     return z || n;
            default: return 1'b1;
        endcase
    endfunction

    function automatic void model_reset();
        m_pc      = RV;
        m_jumped  = 1'b0;
        m_wrapped = 1'b0;
    endfunction

    task automatic drive(input logic en, input logic clr, input logic [15:0] a,
                         input logic c, input logic [2:0] j, input logic z, input logic n);
        bus.en   = en;
        bus.clr  = clr;
        bus.a_in = a;
        bus.is_c = c;
        bus.jmp  = j;
        bus.zr   = z;
        bus.ng   = n;
        #1;
    endtask

    // model the coming edge from the driven inputs, queue the expectation, then clock
    task automatic cycle();
        if (rst_n) begin
            if (bus.clr) begin
                model_reset();
            end else if (bus.en) begin
                if (exp_take(bus.is_c, bus.jmp, bus.zr, bus.ng)) begin
                    m_pc     = bus.a_in;
                    m_jumped = 1'b1;
                end else begin
                    if (m_pc == 16'hFFFF) m_wrapped = 1'b1;
                    m_pc     = m_pc + 16'd1;
                    m_jumped = 1'b0;
                end
            end
        end
        sb.push_back('{m_pc, m_jumped, m_wrapped});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, JNULL, 1'b0, 1'b0);
        model_reset();
        #2;
        n_cmp++;
        if ({bus.pc, bus.jumped, bus.wrapped} !== {RV, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: pc=%h j=%b w=%b required pc=%h j=0 w=0", bus.pc, bus.jumped, bus.wrapped, RV);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_count();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 16'hBEEF, 1'b0, JMP, 1'b0, 1'b0);
            n_cmp++;
            if (bus.take !== 1'b0) begin
                n_fail++;
                $display("FAIL count_take: take=%b required 0", bus.take);
            end
            cycle();
            e = sb.pop_front();
            n_cmp++;
            if ({bus.pc, bus.jumped, bus.wrapped} !== {e.pc, e.jumped, e.wrapped} || bus.pc !== 16'(i + 1)) begin
                n_fail++;
                $display("FAIL count[%0d]: pc=%h j=%b w=%b required pc=%h j=%b w=%b", i, bus.pc, bus.jumped, bus.wrapped, e.pc, e.jumped, e.wrapped);
            end
        end
    endtask

    task automatic test_jump();
        drive(1'b1, 1'b0, 16'h0005, 1'b1, JMP, 1'b0, 1'b0);
        cycle();
        e = sb.pop_front();
        drive(1'b1, 1'b0, 16'h0040, 1'b1, JGT, 1'b0, 1'b0);
        n_cmp++;
        if (bus.pc !== 16'h0005 || bus.take !== 1'b1) begin
            n_fail++;
            $display("FAIL jgt_setup: pc=%h take=%b required pc=0005 take=1", bus.pc, bus.take);
        end
        cycle();
        e = sb.pop_front();
        n_cmp++;
        if ({bus.pc, bus.jumped} !== {16'h0040, 1'b1} || {bus.pc, bus.jumped, bus.wrapped} !== {e.pc, e.jumped, e.wrapped}) begin
            n_fail++;
            $display("FAIL jgt_taken: pc=%h j=%b required pc=0040 j=1", bus.pc, bus.jumped);
        end
        drive(1'b1, 1'b0, 16'h0005, 1'b1, JMP, 1'b0, 1'b0);
        cycle();
        e = sb.pop_front();
        drive(1'b1, 1'b0, 16'h0040, 1'b1, JGT, 1'b0, 1'b1);
        n_cmp++;
        if (bus.take !== 1'b0) begin
            n_fail++;
            $display("FAIL jgt_neg_take: take=%b required 0", bus.take);
        end
        cycle();
        e = sb.pop_front();
        n_cmp++;
        if ({bus.pc, bus.jumped} !== {16'h0006, 1'b0} || {bus.pc, bus.jumped, bus.wrapped} !== {e.pc, e.jumped, e.wrapped}) begin
            n_fail++;
            $display("FAIL jgt_not_taken: pc=%h j=%b required pc=0006 j=0", bus.pc, bus.jumped);
        end
    endtask

    task automatic test_sweep();
        logic [1:0] flags [3];
        flags[0] = 2'b00;
        flags[1] = 2'b10;
        flags[2] = 2'b01;
        for (int j = 0; j < 8; j++) begin
            for (int f = 0; f < 3; f++) begin
                logic t;
                drive(1'b1, 1'b0, 16'h1234, 1'b1, 3'(j), flags[f][1], flags[f][0]);
                t = exp_take(1'b1, 3'(j), flags[f][1], flags[f][0]);
                n_cmp++;
                if (bus.take !== t) begin
                    n_fail++;
                    $display("FAIL sweep_take j=%0d zr=%b ng=%b: take=%b required %b", j, flags[f][1], flags[f][0], bus.take, t);
                end
                cycle();
                e = sb.pop_front();
                n_cmp++;
                if ({bus.pc, bus.jumped, bus.wrapped} !== {e.pc, e.jumped, e.wrapped}) begin
                    n_fail++;
                    $display("FAIL sweep_pc j=%0d zr=%b ng=%b: pc=%h j=%b required pc=%h j=%b", j, flags[f][1], flags[f][0], bus.pc, bus.jumped, e.pc, e.jumped);
                end
            end
        end
        drive(1'b1, 1'b0, 16'h1234, 1'b0, JMP, 1'b1, 1'b1);
        n_cmp++;
        if (bus.take !== 1'b0) begin
            n_fail++;
            $display("FAIL a_instr_take: take=%b required 0", bus.take);
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b0, 16'hFFFF, 1'b1, JMP, 1'b0, 1'b0);
        cycle();
        e = sb.pop_front();
        n_cmp++;
        if ({bus.pc, bus.jumped, bus.wrapped} !== {16'hFFFF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL jump_to_ones: pc=%h j=%b w=%b required pc=ffff j=1 w=0", bus.pc, bus.jumped, bus.wrapped);
        end
        drive(1'b1, 1'b0, 16'h0000, 1'b0, JNULL, 1'b0, 1'b0);
        cycle();
        e = sb.pop_front();
        n_cmp++;
        if ({bus.pc, bus.jumped, bus.wrapped} !== {16'h0000, 1'b0, 1'b1} || {bus.pc, bus.wrapped} !== {e.pc, e.wrapped}) begin
            n_fail++;
            $display("FAIL wrap: pc=%h j=%b w=%b required pc=0000 j=0 w=1", bus.pc, bus.jumped, bus.wrapped);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 16'h7777, 1'b1, JMP, 1'b0, 1'b0);
            cycle();
            e = sb.pop_front();
            n_cmp++;
            if ({bus.pc, bus.jumped, bus.wrapped} !== {e.pc, e.jumped, e.wrapped}) begin
                n_fail++;
                $display("FAIL stall[%0d]: pc=%h j=%b w=%b required pc=%h j=%b w=%b", i, bus.pc, bus.jumped, bus.wrapped, e.pc, e.jumped, e.wrapped);
            end
        end
        drive(1'b0, 1'b1, 16'h0000, 1'b0, JNULL, 1'b0, 1'b0);
        cycle();
        e = sb.pop_front();
        n_cmp++;
        if ({bus.pc, bus.jumped, bus.wrapped} !== {RV, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL clr_wrap: pc=%h w=%b required pc=%h w=0", bus.pc, bus.wrapped, RV);
        end
    endtask

    task automatic test_jumped_stall();
        drive(1'b1, 1'b0, 16'h0300, 1'b1, JMP, 1'b0, 1'b0);
        cycle();
        e = sb.pop_front();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, JNULL, 1'b0, 1'b0);
        cycle();
        e = sb.pop_front();
        n_cmp++;
        if ({bus.pc, bus.jumped} !== {16'h0300, 1'b1} || {bus.pc, bus.jumped} !== {e.pc, e.jumped}) begin
            n_fail++;
            $display("FAIL jumped_hold: pc=%h j=%b required pc=0300 j=1", bus.pc, bus.jumped);
        end
    endtask

    task automatic test_clr_jump();
        drive(1'b1, 1'b1, 16'h0100, 1'b1, JMP, 1'b0, 1'b0);
        n_cmp++;
        if (bus.take !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_take: take=%b required 1", bus.take);
        end
        cycle();
        e = sb.pop_front();
        n_cmp++;
        if ({bus.pc, bus.jumped, bus.wrapped} !== {RV, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL clr_over_jump: pc=%h j=%b required pc=%h j=0", bus.pc, bus.jumped, RV);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 16'h0020, 1'b1, JMP, 1'b0, 1'b0);
        cycle();
        e = sb.pop_front();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, JNULL, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({bus.pc, bus.jumped} !== {RV, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: pc=%h j=%b required pc=%h j=0", bus.pc, bus.jumped, RV);
        end
        drive(1'b1, 1'b0, 16'h0999, 1'b1, JMP, 1'b0, 1'b0);
        cycle();
        e = sb.pop_front();
        n_cmp++;
        if ({bus.pc, bus.jumped, bus.wrapped} !== {e.pc, e.jumped, e.wrapped} || bus.pc !== RV) begin
            n_fail++;
            $display("FAIL reset_over_jump: pc=%h j=%b required pc=%h j=0", bus.pc, bus.jumped, RV);
        end
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 16'h0000, 1'b0, JNULL, 1'b0, 1'b0);
        cycle();
        e = sb.pop_front();
        n_cmp++;
        if ({bus.pc, bus.jumped} !== {16'h0001, 1'b0} || bus.pc !== e.pc) begin
            n_fail++;
            $display("FAIL post_reset_inc: pc=%h required 0001", bus.pc);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_count();
        test_jump();
        test_sweep();
        test_wrap();
        test_jumped_stall();
        test_clr_jump();
        test_async_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
